// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control constants: sequencer state encoding, write-back
// select for loads, and the NOP control pattern used by the pipeline registers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LD_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_e;

  localparam logic [1:0] LOAD_SEL     = 2'b01;
  localparam logic [4:0] OP_ALU_PASSB = 5'b10011;
  localparam logic       S_MXSE_NOP   = 1'b1;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard sequencer.
// Handshake: DM_READY=1 in a cycle means the EX/MEM memory access completes
// in that cycle; the sequencer holds the front end (EN_*=0) until it does.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] ID_RA;
  logic [REG_AW-1:0] ID_RB;
  logic              ID_USE_A;
  logic              ID_USE_B;
  logic [REG_AW-1:0] EX_WC;
  logic              EX_W_RB;
  logic [1:0]        EX_S_MXRB;
  logic              EX_W_DM;
  logic              DM_READY;
  logic              BR_TAKEN;
  logic              EN_PC;
  logic              EN_IFID;
  logic              EN_IDEX;
  logic              FLUSH_IFID;
  logic              BUBBLE_IDEX;
  logic [1:0]        STATE;
  logic [CNT_W-1:0]  STALL_COUNT;
  logic              MEM_TO_ERR;

  modport master (
    output ID_RA, ID_RB, ID_USE_A, ID_USE_B, EX_WC, EX_W_RB, EX_S_MXRB,
           EX_W_DM, DM_READY, BR_TAKEN,
    input  EN_PC, EN_IFID, EN_IDEX, FLUSH_IFID, BUBBLE_IDEX, STATE,
           STALL_COUNT, MEM_TO_ERR
  );

  modport slave (
    input  ID_RA, ID_RB, ID_USE_A, ID_USE_B, EX_WC, EX_W_RB, EX_S_MXRB,
           EX_W_DM, DM_READY, BR_TAKEN,
    output EN_PC, EN_IFID, EN_IDEX, FLUSH_IFID, BUBBLE_IDEX, STATE,
           STALL_COUNT, MEM_TO_ERR
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Combinational detector: memory operation in EX/MEM and load-use dependency
// between the EX/MEM load destination and the ID-stage sources.
module hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] i_id_ra,
  input  logic [REG_AW-1:0] i_id_rb,
  input  logic              i_id_use_a,
  input  logic              i_id_use_b,
  input  logic [REG_AW-1:0] i_ex_wc,
  input  logic              i_ex_w_rb,
  input  logic [1:0]        i_ex_s_mxrb,
  input  logic              i_ex_w_dm,
  output logic              o_mem_op,
  output logic              o_ld_use
);
  logic w_is_load;
  logic w_hit_a;
  logic w_hit_b;

  assign w_is_load = i_ex_w_rb & (i_ex_s_mxrb == LOAD_SEL);
  assign w_hit_a   = i_id_use_a & (i_id_ra == i_ex_wc);
  assign w_hit_b   = i_id_use_b & (i_id_rb == i_ex_wc);
  assign o_mem_op  = i_ex_w_dm | w_is_load;
  assign o_ld_use  = w_is_load & (w_hit_a | w_hit_b);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end sequencer: stalls on memory waits, bubbles on load-use hazards,
// flushes on taken branches. Control outputs are Mealy on state and inputs.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  pipe_hazard_ctrl_if.slave bus
);
  localparam bit       LD_MULTI  = (LOAD_LAT > 1);
  localparam bit [2:0] LD_LAST   = 3'(LOAD_LAT - 1);
  localparam bit [7:0] WAIT_LAST = 8'(MEM_TIMEOUT);

  state_e           r_state;
  logic             r_run;
  logic [2:0]       r_ld_cnt;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_mem_err;

  state_e     w_state_nxt;
  logic [2:0] w_ld_cnt_nxt;
  logic [7:0] w_wait_cnt_nxt;
  logic       w_set_err;
  logic       w_mem_op;
  logic       w_ld_use;
  logic       w_en_pc;
  logic       w_en_ifid;
  logic       w_en_idex;
  logic       w_flush;
  logic       w_bubble;

  hazard_cmp #(.REG_AW(REG_AW)) u_cmp (
    .i_id_ra     (bus.ID_RA),
    .i_id_rb     (bus.ID_RB),
    .i_id_use_a  (bus.ID_USE_A),
    .i_id_use_b  (bus.ID_USE_B),
    .i_ex_wc     (bus.EX_WC),
    .i_ex_w_rb   (bus.EX_W_RB),
    .i_ex_s_mxrb (bus.EX_S_MXRB),
    .i_ex_w_dm   (bus.EX_W_DM),
    .o_mem_op    (w_mem_op),
    .o_ld_use    (w_ld_use)
  );

  always_comb begin
    w_en_pc        = 1'b1;
    w_en_ifid      = 1'b1;
    w_en_idex      = 1'b1;
    w_flush        = 1'b0;
    w_bubble       = 1'b0;
    w_state_nxt    = r_state;
    w_ld_cnt_nxt   = r_ld_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    w_set_err      = 1'b0;
    // r_run is cleared asynchronously, so this also covers the reset window
    // and the cycle between deassertion and the first clock edge.
    if (!r_run) begin
      w_en_pc   = 1'b0;
      w_en_ifid = 1'b0;
      w_en_idex = 1'b0;
      w_flush   = 1'b1;
      w_bubble  = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_op && !bus.DM_READY) begin
            w_en_pc        = 1'b0;
            w_en_ifid      = 1'b0;
            w_en_idex      = 1'b0;
            w_state_nxt    = ST_MEM_WAIT;
            w_wait_cnt_nxt = 8'd1;
          end else if (bus.BR_TAKEN) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
          end else if (w_ld_use) begin
            w_en_pc   = 1'b0;
            w_en_ifid = 1'b0;
            w_bubble  = 1'b1;
            if (LD_MULTI) begin
              w_state_nxt  = ST_LD_STALL;
              w_ld_cnt_nxt = 3'd1;
            end
          end
        end
        ST_LD_STALL: begin
          if (bus.BR_TAKEN) begin
            w_flush     = 1'b1;
            w_bubble    = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_en_pc      = 1'b0;
            w_en_ifid    = 1'b0;
            w_bubble     = 1'b1;
            w_ld_cnt_nxt = r_ld_cnt + 3'd1;
            if (r_ld_cnt == LD_LAST) w_state_nxt = ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (bus.DM_READY) begin
            // The completing load may still feed the ID instruction.
            w_state_nxt = ST_RUN;
            if (w_ld_use) begin
              w_en_pc   = 1'b0;
              w_en_ifid = 1'b0;
              w_bubble  = 1'b1;
              if (LD_MULTI) begin
                w_state_nxt  = ST_LD_STALL;
                w_ld_cnt_nxt = 3'd1;
              end
            end
          end else if (r_wait_cnt == WAIT_LAST) begin
            w_set_err   = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_en_pc        = 1'b0;
            w_en_ifid      = 1'b0;
            w_en_idex      = 1'b0;
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_RUN;
      r_run       <= 1'b0;
      r_ld_cnt    <= 3'd0;
      r_wait_cnt  <= 8'd0;
      r_stall_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_state    <= w_state_nxt;
      r_ld_cnt   <= w_ld_cnt_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_set_err) r_mem_err <= 1'b1;
      if (r_run && !w_en_pc && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.EN_PC       = w_en_pc;
  assign bus.EN_IFID     = w_en_ifid;
  assign bus.EN_IDEX     = w_en_idex;
  assign bus.FLUSH_IFID  = w_flush;
  assign bus.BUBBLE_IDEX = w_bubble;
  assign bus.STATE       = r_state;
  assign bus.STALL_COUNT = r_stall_cnt;
  assign bus.MEM_TO_ERR  = r_mem_err;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: two instances (LOAD_LAT=1 and 3) see
// identical stimulus; ctl vectors are {EN_PC,EN_IFID,EN_IDEX,FLUSH,BUBBLE}.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  pipe_hazard_ctrl_if #(.REG_AW(4), .CNT_W(16)) if0 ();
  pipe_hazard_ctrl_if #(.REG_AW(4), .CNT_W(16)) if1 ();

  pipe_hazard_ctrl #(.REG_AW(4), .LOAD_LAT(1), .MEM_TIMEOUT(15), .CNT_W(16)) u0 (
    .CLK(clk), .RESET_N(rst_n), .bus(if0.slave));
  pipe_hazard_ctrl #(.REG_AW(4), .LOAD_LAT(3), .MEM_TIMEOUT(15), .CNT_W(16)) u1 (
    .CLK(clk), .RESET_N(rst_n), .bus(if1.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ctl0();
    return {if0.EN_PC, if0.EN_IFID, if0.EN_IDEX, if0.FLUSH_IFID, if0.BUBBLE_IDEX};
  endfunction
  function automatic logic [4:0] ctl1();
    return {if1.EN_PC, if1.EN_IFID, if1.EN_IDEX, if1.FLUSH_IFID, if1.BUBBLE_IDEX};
  endfunction

  // driver tasks
  task automatic set_in(input logic [3:0] ra, input logic [3:0] rb,
                        input logic use_a, input logic use_b,
                        input logic [3:0] wc, input logic w_rb,
                        input logic [1:0] s_mxrb, input logic w_dm,
                        input logic dm_rdy, input logic br);
    if0.ID_RA = ra;  if0.ID_RB = rb;  if0.ID_USE_A = use_a;  if0.ID_USE_B = use_b;
    if0.EX_WC = wc;  if0.EX_W_RB = w_rb;  if0.EX_S_MXRB = s_mxrb;
    if0.EX_W_DM = w_dm;  if0.DM_READY = dm_rdy;  if0.BR_TAKEN = br;
    if1.ID_RA = ra;  if1.ID_RB = rb;  if1.ID_USE_A = use_a;  if1.ID_USE_B = use_b;
    if1.EX_WC = wc;  if1.EX_W_RB = w_rb;  if1.EX_S_MXRB = s_mxrb;
    if1.EX_W_DM = w_dm;  if1.DM_READY = dm_rdy;  if1.BR_TAKEN = br;
  endtask

  task automatic idle();
    set_in(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic ld_use_in(input logic br);
    set_in(4'h3, 4'h0, 1'b1, 1'b0, 4'h3, 1'b1, 2'b01, 1'b0, 1'b1, br);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    set_in(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    #1;
    n_chk++; if (ctl0() !== 5'b00000) $display("FAIL rst_enter_wait ctl got=%b exp=00000", ctl0()); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (if0.STATE !== 2'b10) $display("FAIL rst_in_wait state got=%b exp=10", if0.STATE); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (if0.STATE !== 2'b00) $display("FAIL rst_async state got=%b exp=00", if0.STATE); else n_pass++;
    n_chk++; if (if0.STALL_COUNT !== 16'd0) $display("FAIL rst_async cnt got=%0d exp=0", if0.STALL_COUNT); else n_pass++;
    n_chk++; if (ctl0() !== 5'b00011) $display("FAIL rst_async ctl got=%b exp=00011", ctl0()); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    n_chk++; if (ctl0() !== 5'b00011) $display("FAIL rst_predge ctl got=%b exp=00011", ctl0()); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (ctl0() !== 5'b11100) $display("FAIL rst_first_run ctl got=%b exp=11100", ctl0()); else n_pass++;
    n_chk++; if (if0.STALL_COUNT !== 16'd0) $display("FAIL rst_first_run cnt got=%0d exp=0", if0.STALL_COUNT); else n_pass++;
    n_chk++; if (if0.MEM_TO_ERR !== 1'b0) $display("FAIL rst_first_run err got=%b exp=0", if0.MEM_TO_ERR); else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    ld_use_in(1'b0);
    #1;
    n_chk++; if (ctl0() !== 5'b00101) $display("FAIL ld_c1 u0 ctl got=%b exp=00101", ctl0()); else n_pass++;
    n_chk++; if (ctl1() !== 5'b00101) $display("FAIL ld_c1 u1 ctl got=%b exp=00101", ctl1()); else n_pass++;
    n_chk++; if (if1.STATE !== 2'b00) $display("FAIL ld_c1 u1 state got=%b exp=00", if1.STATE); else n_pass++;
    @(negedge clk);
    idle();
    #1;
    n_chk++; if (ctl0() !== 5'b11100) $display("FAIL ld_c2 u0 ctl got=%b exp=11100", ctl0()); else n_pass++;
    n_chk++; if (if0.STALL_COUNT !== 16'd1) $display("FAIL ld_c2 u0 cnt got=%0d exp=1", if0.STALL_COUNT); else n_pass++;
    n_chk++; if (ctl1() !== 5'b00101) $display("FAIL ld_c2 u1 ctl got=%b exp=00101", ctl1()); else n_pass++;
    n_chk++; if (if1.STATE !== 2'b01) $display("FAIL ld_c2 u1 state got=%b exp=01", if1.STATE); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (ctl1() !== 5'b00101) $display("FAIL ld_c3 u1 ctl got=%b exp=00101", ctl1()); else n_pass++;
    n_chk++; if (if1.STATE !== 2'b01) $display("FAIL ld_c3 u1 state got=%b exp=01", if1.STATE); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (ctl1() !== 5'b11100) $display("FAIL ld_c4 u1 ctl got=%b exp=11100", ctl1()); else n_pass++;
    n_chk++; if (if1.STATE !== 2'b00) $display("FAIL ld_c4 u1 state got=%b exp=00", if1.STATE); else n_pass++;
    n_chk++; if (if1.STALL_COUNT !== 16'd3) $display("FAIL ld_c4 u1 cnt got=%0d exp=3", if1.STALL_COUNT); else n_pass++;
    n_chk++; if (if0.STALL_COUNT !== 16'd1) $display("FAIL ld_c4 u0 cnt got=%0d exp=1", if0.STALL_COUNT); else n_pass++;
  endtask

  task automatic test_no_hazard();
    do_reset();
    @(negedge clk);
    set_in(4'h5, 4'h3, 1'b1, 1'b0, 4'h3, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    #1;
    n_chk++; if (ctl0() !== 5'b11100) $display("FAIL nohz_useb_off ctl got=%b exp=11100", ctl0()); else n_pass++;
    @(negedge clk);
    set_in(4'h3, 4'h3, 1'b1, 1'b1, 4'h3, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
    #1;
    n_chk++; if (ctl0() !== 5'b11100) $display("FAIL nohz_alu_wb ctl got=%b exp=11100", ctl0()); else n_pass++;
    @(negedge clk);
    set_in(4'h5, 4'h3, 1'b1, 1'b1, 4'h3, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
    #1;
    n_chk++; if (ctl0() !== 5'b00101) $display("FAIL hz_rb ctl got=%b exp=00101", ctl0()); else n_pass++;
  endtask

  task automatic test_mem_wait();
    logic [4:0] exp_ctl;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      set_in(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b1, (k == 5), (k == 3));
      #1;
      exp_ctl = (k == 5) ? 5'b11100 : 5'b00000;
      n_chk++; if (ctl0() !== exp_ctl) $display("FAIL memw_c%0d ctl got=%b exp=%b", k, ctl0(), exp_ctl); else n_pass++;
      n_chk++; if (if0.STATE !== ((k == 1) ? 2'b00 : 2'b10)) $display("FAIL memw_c%0d state got=%b", k, if0.STATE); else n_pass++;
    end
    @(negedge clk);
    idle();
    #1;
    n_chk++; if (if0.STATE !== 2'b00) $display("FAIL memw_done state got=%b exp=00", if0.STATE); else n_pass++;
    n_chk++; if (if0.STALL_COUNT !== 16'd4) $display("FAIL memw_done cnt got=%0d exp=4", if0.STALL_COUNT); else n_pass++;
    n_chk++; if (if0.MEM_TO_ERR !== 1'b0) $display("FAIL memw_done err got=%b exp=0", if0.MEM_TO_ERR); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [4:0] exp_ctl;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) set_in(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      #1;
      exp_ctl = (k == 16) ? 5'b11100 : 5'b00000;
      n_chk++; if (ctl0() !== exp_ctl) $display("FAIL tmo_c%0d ctl got=%b exp=%b", k, ctl0(), exp_ctl); else n_pass++;
    end
    n_chk++; if (if0.STALL_COUNT !== 16'd15) $display("FAIL tmo_cnt got=%0d exp=15", if0.STALL_COUNT); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (if0.MEM_TO_ERR !== 1'b1) $display("FAIL tmo_err_set got=%b exp=1", if0.MEM_TO_ERR); else n_pass++;
    n_chk++; if (if0.STATE !== 2'b00) $display("FAIL tmo_back_run state got=%b exp=00", if0.STATE); else n_pass++;
    @(negedge clk);
    idle();
    #1;
    n_chk++; if (if0.MEM_TO_ERR !== 1'b1) $display("FAIL tmo_err_sticky got=%b exp=1", if0.MEM_TO_ERR); else n_pass++;
    n_chk++; if (ctl0() !== 5'b11100) $display("FAIL tmo_after ctl got=%b exp=11100", ctl0()); else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk);
    ld_use_in(1'b1);
    #1;
    n_chk++; if (ctl0() !== 5'b11111) $display("FAIL br_ld u0 ctl got=%b exp=11111", ctl0()); else n_pass++;
    n_chk++; if (ctl1() !== 5'b11111) $display("FAIL br_ld u1 ctl got=%b exp=11111", ctl1()); else n_pass++;
    @(negedge clk);
    idle();
    #1;
    n_chk++; if (if1.STATE !== 2'b00) $display("FAIL br_ld u1 state got=%b exp=00", if1.STATE); else n_pass++;
    n_chk++; if (if1.STALL_COUNT !== 16'd0) $display("FAIL br_ld u1 cnt got=%0d exp=0", if1.STALL_COUNT); else n_pass++;
    @(negedge clk);
    ld_use_in(1'b0);
    @(negedge clk);
    idle();
    if1.BR_TAKEN = 1'b1;
    if0.BR_TAKEN = 1'b1;
    #1;
    n_chk++; if (if1.STATE !== 2'b01) $display("FAIL br_stall u1 state got=%b exp=01", if1.STATE); else n_pass++;
    n_chk++; if (ctl1() !== 5'b11111) $display("FAIL br_stall u1 ctl got=%b exp=11111", ctl1()); else n_pass++;
    @(negedge clk);
    idle();
    #1;
    n_chk++; if (if1.STATE !== 2'b00) $display("FAIL br_stall_exit u1 state got=%b exp=00", if1.STATE); else n_pass++;
    n_chk++; if (if1.STALL_COUNT !== 16'd1) $display("FAIL br_stall_exit u1 cnt got=%0d exp=1", if1.STALL_COUNT); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    set_in(4'h3, 4'h0, 1'b1, 1'b0, 4'h3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    #1;
    n_chk++; if (ctl0() !== 5'b00000) $display("FAIL b2b_memwins ctl got=%b exp=00000", ctl0()); else n_pass++;
    @(negedge clk);
    if0.DM_READY = 1'b1;
    if1.DM_READY = 1'b1;
    #1;
    n_chk++; if (ctl0() !== 5'b00101) $display("FAIL b2b_ready u0 ctl got=%b exp=00101", ctl0()); else n_pass++;
    n_chk++; if (ctl1() !== 5'b00101) $display("FAIL b2b_ready u1 ctl got=%b exp=00101", ctl1()); else n_pass++;
    @(negedge clk);
    idle();
    #1;
    n_chk++; if (ctl0() !== 5'b11100) $display("FAIL b2b_after u0 ctl got=%b exp=11100", ctl0()); else n_pass++;
    n_chk++; if (if1.STATE !== 2'b01) $display("FAIL b2b_after u1 state got=%b exp=01", if1.STATE); else n_pass++;
    n_chk++; if (if0.STALL_COUNT !== 16'd2) $display("FAIL b2b_after u0 cnt got=%0d exp=2", if0.STALL_COUNT); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_wait();
    test_timeout();
    test_branch();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer that drives the ENABLE and bubble-insert controls of the IF/ID and ID→EX/MEM pipeline registers, and the PC write enable.
- Detects load-use hazards, multi-cycle data-memory waits and taken branches.
- Stalls, bubbles or flushes the front end accordingly.
- Sits beside the decoder; consumes ID-stage source fields and EX/MEM-stage control fields.

Parameters:
REG_AW, 4, register-address width; matches the WC field.
LOAD_LAT, 1, load-use stall cycles; legal range 1..7.
MEM_TIMEOUT, 15, maximum DM wait cycles before forced release; legal range 1..255.
CNT_W, 16, stall-counter width.

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
ID_RA  in  REG_AW  ID-stage source A address
ID_RB  in  REG_AW  ID-stage source B address
ID_USE_A  in  1  ID instruction reads A
ID_USE_B  in  1  ID instruction reads B
EX_WC  in  REG_AW  EX/MEM destination register
EX_W_RB  in  1  EX/MEM writes register bank
EX_S_MXRB  in  2  EX/MEM write-back select; LOAD_SEL=2'b01 means memory data
EX_W_DM  in  1  EX/MEM store
DM_READY  in  1  data memory completes access this cycle
BR_TAKEN  in  1  branch resolved taken in EX/MEM
EN_PC  out  1  PC write enable
EN_IFID  out  1  IF/ID register ENABLE
EN_IDEX  out  1  ID→EX/MEM register ENABLE
FLUSH_IFID  out  1  load NOP into IF/ID
BUBBLE_IDEX  out  1  force NOP controls into ID→EX/MEM: OP_ALU=5'b10011, W_DM=0, W_RB=0, W_RF=0, S_MXSE=1
STATE  out  2  current state, for debug
STALL_COUNT  out  CNT_W  cycles with EN_PC=0; saturating
MEM_TO_ERR  out  1  sticky: memory timeout occurred

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - STATE=RUN; internal counters=0; STALL_COUNT=0; MEM_TO_ERR=0.
  - Outputs held in the safe state: EN_*=0, FLUSH_IFID=1, BUBBLE_IDEX=1.
  - Deassertion takes effect at the next CLK edge.
- Definitions:
  - mem_op = EX_W_DM | (EX_W_RB & EX_S_MXRB==LOAD_SEL).
  - ld_use = EX_W_RB & EX_S_MXRB==LOAD_SEL & ((ID_USE_A & ID_RA==EX_WC) | (ID_USE_B & ID_RB==EX_WC)).
- States: RUN=2'b00, LD_STALL=2'b01, MEM_WAIT=2'b10. Outputs are Mealy (state plus current inputs).
- RUN, priority order:
  1. mem_op & !DM_READY: all EN_*=0, no flush or bubble; next MEM_WAIT; wait_cnt←1.
  2. BR_TAKEN: all EN_*=1, FLUSH_IFID=1, BUBBLE_IDEX=1; stay in RUN. Branch beats ld_use because the ID instruction is wrong-path.
  3. ld_use: EN_PC=0, EN_IFID=0, EN_IDEX=1, BUBBLE_IDEX=1. If LOAD_LAT>1, next LD_STALL with ld_cnt←1; else stay in RUN.
  4. Otherwise: all EN_*=1, FLUSH_IFID=0, BUBBLE_IDEX=0.
- LD_STALL:
  - EN_PC=0, EN_IFID=0, EN_IDEX=1, BUBBLE_IDEX=1; ld_cnt increments.
  - When ld_cnt==LOAD_LAT-1, next RUN.
  - BR_TAKEN here takes the RUN case-2 action and returns to RUN immediately.
- MEM_WAIT:
  - EN_*=DM_READY; no bubble.
  - DM_READY=1: next RUN.
  - Else wait_cnt increments. When wait_cnt==MEM_TIMEOUT: set MEM_TO_ERR, force all EN_*=1 that cycle, next RUN.
  - BR_TAKEN is ignored while in MEM_WAIT.
- STALL_COUNT increments on every post-reset cycle with EN_PC=0 and saturates at all-ones.
- MEM_TO_ERR is cleared only by reset.
- Simultaneous mem_op & ld_use in RUN: the memory wait wins. ld_use is re-evaluated on the cycle DM_READY arrives.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding constants;
  - LOAD_SEL;
  - NOP control constants (OP_ALU_PASSB=5'b10011, S_MXSE_NOP=1'b1), shared with the pipeline registers.
- One natural sub-module, hazard_cmp: a combinational ld_use/mem_op detector parameterised by REG_AW.

Test Plan:
1. Reset mid-MEM_WAIT (RESET_N low for 1 cycle) -> STATE=00, STALL_COUNT=0, EN_PC=0, BUBBLE_IDEX=1 immediately; EN_*=1 on the first clean RUN cycle.
2. EX_W_RB=1, EX_S_MXRB=01, EX_WC=4'h3, ID_RA=4'h3, ID_USE_A=1, LOAD_LAT=1 -> exactly one cycle of EN_PC=0, EN_IFID=0, BUBBLE_IDEX=1; STALL_COUNT=1.
3. Same as scenario 2 with LOAD_LAT=3 -> three consecutive bubble cycles with STATE 00→01→01→00; STALL_COUNT=3.
4. EX_W_DM=1 with DM_READY low for 4 cycles, then high -> EN_*=0 for 4 cycles and EN_*=1 on the 5th; STATE returns to 00; MEM_TO_ERR=0.
5. DM_READY held low with MEM_TIMEOUT=15 -> release on the 15th MEM_WAIT cycle; MEM_TO_ERR=1 and stays 1.
6. BR_TAKEN=1 together with ld_use in RUN -> FLUSH_IFID=1, BUBBLE_IDEX=1, EN_PC=1; no LD_STALL entered; STALL_COUNT unchanged.
